// File: rtl/cam_pkg.sv
// Shared types and sizes for the CAM request path.
// The CAM itself and its request controller both import these, so the key
// width and entry count are defined in one place only.
package cam_pkg;

  localparam int KEY_W = 8;
  localparam int DEPTH = 8;

  typedef enum logic {
    OP_LOOKUP = 1'b0,
    OP_INSERT = 1'b1
  } cam_op_e;

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    LOOKUP,
    CHECK,
    WRITE,
    RESP
  } cam_ctrl_state_e;

endpackage

// File: rtl/cam_alloc.sv
// Slot allocator for the CAM: round-robin write pointer plus a saturating
// count of slots that have been written since reset.
// The pointer wraps naturally because DEPTH is a power of two, which is what
// gives FIFO-order eviction once the CAM is full.
module cam_alloc
  import cam_pkg::*;
#(
  parameter int DEPTH  = cam_pkg::DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              adv,
  input  logic              clr,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W:0]   occupancy
);

  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

  // Advance the pointer on every write; occupancy stops counting at DEPTH.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wr_ptr    <= '0;
      occupancy <= '0;
    end else if (adv) begin
      wr_ptr <= wr_ptr + ADDR_W'(1);
      if (occupancy != FULL) begin
        occupancy <= occupancy + (ADDR_W+1)'(1);
      end
    end
  end

endmodule

// File: rtl/cam_req_ctrl.sv
// Request sequencer sitting directly in front of the 8x8 CAM.
// Takes lookup/insert requests over valid/ready, presents the key to the CAM,
// waits one cycle for the registered match flag, writes new keys round-robin
// and returns hit/evict status over a held valid/ready response.
// Optional build macro CAM_FLUSH_EN: after reset the controller first writes
// PAD_KEY into every slot so stale contents can never produce a hit.
module cam_req_ctrl #(
  parameter int               KEY_W   = cam_pkg::KEY_W,
  parameter int               DEPTH   = cam_pkg::DEPTH,
  parameter int               ADDR_W  = $clog2(DEPTH),
  parameter logic [KEY_W-1:0] PAD_KEY = '1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_op,
  input  logic [KEY_W-1:0]  req_key,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_hit,
  output logic              rsp_evict,
  output logic [ADDR_W:0]   occupancy,
  output logic [KEY_W-1:0]  cam_key,
  output logic              cam_we,
  output logic [ADDR_W-1:0] cam_waddr,
  input  logic              cam_hit
);

  import cam_pkg::*;

  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

  cam_ctrl_state_e   state;
  cam_op_e           op;
  logic [ADDR_W-1:0] wr_ptr;
  logic              alloc_adv;
  logic              alloc_clr;

`ifdef CAM_FLUSH_EN
  logic [ADDR_W-1:0] flush_ptr;
  logic              flush_done;

  assign alloc_clr = (state == FLUSH);
`else
  assign alloc_clr = 1'b0;
`endif

  assign alloc_adv = (state == WRITE);

  cam_alloc #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_alloc (
    .clk       (clk),
    .rst_n     (rst_n),
    .adv       (alloc_adv),
    .clr       (alloc_clr),
    .wr_ptr    (wr_ptr),
    .occupancy (occupancy)
  );

  // Request FSM; every outward signal is a register updated here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
`ifdef CAM_FLUSH_EN
      state      <= FLUSH;
      flush_ptr  <= '0;
      flush_done <= 1'b0;
`else
      state      <= IDLE;
`endif
      op         <= OP_LOOKUP;
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_hit    <= 1'b0;
      rsp_evict  <= 1'b0;
      cam_key    <= '0;
      cam_we     <= 1'b0;
      cam_waddr  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            op        <= cam_op_e'(req_op);
            cam_key   <= req_key;
            req_ready <= 1'b0;
            rsp_hit   <= 1'b0;
            rsp_evict <= 1'b0;
            state     <= LOOKUP;
          end else begin
            req_ready <= 1'b1;
          end
        end

        LOOKUP: begin
          state <= CHECK;
        end

        CHECK: begin
          rsp_hit   <= cam_hit;
          rsp_evict <= 1'b0;
          if (op == OP_INSERT && !cam_hit) begin
            cam_we    <= 1'b1;
            cam_waddr <= wr_ptr;
            rsp_evict <= (occupancy == FULL);
            state     <= WRITE;
          end else begin
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end

        WRITE: begin
          cam_we    <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        FLUSH: begin
`ifdef CAM_FLUSH_EN
          if (flush_done) begin
            cam_we    <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end else begin
            cam_we    <= 1'b1;
            cam_waddr <= flush_ptr;
            cam_key   <= PAD_KEY;
            flush_ptr <= flush_ptr + ADDR_W'(1);
            if (flush_ptr == ADDR_W'(DEPTH - 1)) begin
              flush_done <= 1'b1;
            end
          end
`else
          state <= IDLE;
`endif
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // The pad key marks unused slots, so a real request must never carry it.
  assert property (@(posedge clk) disable iff (!rst_n)
                   (req_valid && req_ready) |-> (req_key != PAD_KEY));

endmodule

// File: tb/tb_cam_req_ctrl.sv
// Self-checking bench for cam_req_ctrl paired with a behavioural CAM whose
// match flag is registered. Expected results come from a table-level model of
// the CAM contents (keys, round-robin pointer, saturating occupancy).
// Build with CAM_FLUSH_EN to exercise the post-reset flush.
module tb_cam_req_ctrl;

  import cam_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic       req_op;
  logic [7:0] req_key;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_hit;
  logic       rsp_evict;
  logic [3:0] occupancy;
  logic [7:0] cam_key;
  logic       cam_we;
  logic [2:0] cam_waddr;
  logic       cam_hit = 1'b0;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  cam_req_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_key   (req_key),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_hit   (rsp_hit),
    .rsp_evict (rsp_evict),
    .occupancy (occupancy),
    .cam_key   (cam_key),
    .cam_we    (cam_we),
    .cam_waddr (cam_waddr),
    .cam_hit   (cam_hit)
  );

  // Behavioural 8x8 CAM: registered match flag, bench-controlled wipe.
  logic [7:0]       cam_mem [DEPTH];
  logic [DEPTH-1:0] cam_vld = '0;
  logic             cam_clr;
  logic             hit_now;

  always_comb begin
    hit_now = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (cam_vld[i] && cam_mem[i] == cam_key) hit_now = 1'b1;
    end
  end

  always @(posedge clk) begin
    if (cam_clr) begin
      cam_vld <= '0;
    end else if (cam_we) begin
      cam_mem[cam_waddr] <= cam_key;
      cam_vld[cam_waddr] <= 1'b1;
    end
    cam_hit <= hit_now;
  end

  // Reference model of what the CAM should hold.
  int m_key [DEPTH];
  bit m_vld [DEPTH];
  int m_ptr;
  int m_occ;

  function automatic void model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_vld[i] = 1'b0;
      m_key[i] = 0;
    end
    m_ptr = 0;
    m_occ = 0;
  endfunction

  function automatic void model_req(input bit ins, input int k, output bit hit,
                                    output bit ev, output bit wr, output int slot);
    hit  = 1'b0;
    ev   = 1'b0;
    wr   = 1'b0;
    slot = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (m_vld[i] && m_key[i] == k) hit = 1'b1;
    end
    if (ins && !hit) begin
      wr           = 1'b1;
      slot         = m_ptr;
      ev           = (m_occ == DEPTH);
      m_key[m_ptr] = k;
      m_vld[m_ptr] = 1'b1;
      m_ptr        = (m_ptr + 1) % DEPTH;
      if (m_occ < DEPTH) m_occ = m_occ + 1;
    end
  endfunction

  // Observations captured for the most recent request.
  int o_lat;
  int o_nwe;
  int o_waddr;
  int o_wkey;
  int o_occ;
  bit o_hit;
  bit o_evict;
  bit o_busy_rdy;

  // Present one request and wait (bounded) for it to be accepted.
  task automatic send_req(input bit ins, input logic [7:0] k);
    bit ok;
    ok        = 1'b0;
    req_valid = 1'b1;
    req_op    = ins;
    req_key   = k;
    for (int i = 0; i < 20; i++) begin
      if (req_ready === 1'b1) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL accept_timeout key=%h: req_ready never seen high", k);
    end
  endtask

  // Follow the request from acceptance until rsp_valid, recording CAM writes.
  task automatic wait_rsp();
    bit ok;
    ok         = 1'b0;
    o_lat      = 0;
    o_nwe      = 0;
    o_waddr    = -1;
    o_wkey     = -1;
    o_busy_rdy = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (cam_we === 1'b1) begin
        o_nwe++;
        o_waddr = int'(cam_waddr);
        o_wkey  = int'(cam_key);
      end
      if (req_ready !== 1'b0) o_busy_rdy = 1'b1;
      if (rsp_valid === 1'b1) begin
        o_lat = i;
        ok    = 1'b1;
        break;
      end
    end
    o_hit   = rsp_hit;
    o_evict = rsp_evict;
    o_occ   = int'(occupancy);
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL rsp_timeout: rsp_valid not seen within 20 cycles");
    end
  endtask

  // Reset the DUT and wipe the CAM, then wait until requests are accepted.
  task automatic do_reset();
    bit ok;
    ok        = 1'b0;
    rst_n     = 1'b0;
    cam_clr   = 1'b1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n   = 1'b1;
    cam_clr = 1'b0;
    model_clear();
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (req_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL reset_ready_timeout: req_ready stayed low");
    end
  endtask

  task automatic test_reset();
    int n;
    rst_n     = 1'b0;
    cam_clr   = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_op    = 1'($urandom_range(0, 1));
      req_key   = 8'($urandom_range(0, 255));
      @(posedge clk); #1;
      vectors++;
      if ({req_ready, rsp_valid, rsp_hit, rsp_evict, cam_we, cam_key, cam_waddr, occupancy} !== '0) begin
        miscompares++;
        $display("[TB] FAIL reset_outputs cycle %0d: got rr=%b rv=%b h=%b e=%b we=%b key=%h wa=%0d occ=%0d want all 0",
                 i, req_ready, rsp_valid, rsp_hit, rsp_evict, cam_we, cam_key, cam_waddr, occupancy);
      end
    end
    rst_n     = 1'b1;
    cam_clr   = 1'b0;
    req_valid = 1'b0;
    model_clear();
`ifdef CAM_FLUSH_EN
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (cam_we === 1'b1) begin
        vectors++;
        if (cam_waddr !== 3'(n) || cam_key !== 8'hFF || req_ready !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL flush_write %0d: got wa=%0d key=%h rr=%b want wa=%0d key=ff rr=0",
                   n, cam_waddr, cam_key, req_ready, n);
        end
        n++;
      end
      if (req_ready === 1'b1) break;
    end
    vectors++;
    if (n !== DEPTH || req_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL flush_count: got %0d writes rr=%b want %0d writes rr=1", n, req_ready, DEPTH);
    end
`else
    n = 0;
    @(posedge clk); #1;
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL ready_after_reset: got %b want 1", req_ready);
    end
`endif
    vectors++;
    if (occupancy !== 4'd0) begin
      miscompares++;
      $display("[TB] FAIL occ_after_reset: got %0d want 0", occupancy);
    end
  endtask

  typedef struct {
    bit         ins;
    logic [7:0] key;
    bit         hit;
    bit         ev;
    int         lat;
    int         nwe;
    int         occ;
  } dir_t;

  task automatic test_insert_lookup();
    dir_t tbl [4];
    bit   mh, me, mw;
    int   ms;
    tbl[0] = '{1'b1, 8'hAA, 1'b0, 1'b0, 3, 1, 1};
    tbl[1] = '{1'b0, 8'hAA, 1'b1, 1'b0, 2, 0, 1};
    tbl[2] = '{1'b0, 8'h55, 1'b0, 1'b0, 2, 0, 1};
    tbl[3] = '{1'b1, 8'hAA, 1'b1, 1'b0, 2, 0, 1};
    for (int i = 0; i < 4; i++) begin
      model_req(tbl[i].ins, int'(tbl[i].key), mh, me, mw, ms);
      send_req(tbl[i].ins, tbl[i].key);
      wait_rsp();
      vectors++;
      if (o_hit !== tbl[i].hit || o_evict !== tbl[i].ev) begin
        miscompares++;
        $display("[TB] FAIL dir_status %0d key=%h: got hit=%b ev=%b want hit=%b ev=%b",
                 i, tbl[i].key, o_hit, o_evict, tbl[i].hit, tbl[i].ev);
      end
      vectors++;
      if (o_lat !== tbl[i].lat) begin
        miscompares++;
        $display("[TB] FAIL dir_latency %0d: got %0d want %0d", i, o_lat, tbl[i].lat);
      end
      vectors++;
      if (o_nwe !== tbl[i].nwe || o_occ !== tbl[i].occ) begin
        miscompares++;
        $display("[TB] FAIL dir_write %0d: got we=%0d occ=%0d want we=%0d occ=%0d",
                 i, o_nwe, o_occ, tbl[i].nwe, tbl[i].occ);
      end
      if (tbl[i].nwe == 1) begin
        vectors++;
        if (o_waddr !== 0 || o_wkey !== int'(tbl[i].key)) begin
          miscompares++;
          $display("[TB] FAIL dir_waddr %0d: got wa=%0d key=%h want wa=0 key=%h",
                   i, o_waddr, o_wkey, tbl[i].key);
        end
      end
    end
  endtask

  task automatic test_fill_evict();
    bit mh, me, mw;
    int ms, elat;
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      model_req(1'b1, k, mh, me, mw, ms);
      elat = mw ? 3 : 2;
      send_req(1'b1, 8'(k));
      wait_rsp();
      vectors++;
      if (o_hit !== mh || o_evict !== me || o_lat !== elat || o_occ !== m_occ) begin
        miscompares++;
        $display("[TB] FAIL fill_status key=%0d: got hit=%b ev=%b lat=%0d occ=%0d want hit=%b ev=%b lat=%0d occ=%0d",
                 k, o_hit, o_evict, o_lat, o_occ, mh, me, elat, m_occ);
      end
      vectors++;
      if (o_nwe !== 1 || o_waddr !== ms || o_wkey !== k) begin
        miscompares++;
        $display("[TB] FAIL fill_write key=%0d: got we=%0d wa=%0d key=%0d want we=1 wa=%0d key=%0d",
                 k, o_nwe, o_waddr, o_wkey, ms, k);
      end
    end
    model_req(1'b0, 1, mh, me, mw, ms);
    send_req(1'b0, 8'h01);
    wait_rsp();
    vectors++;
    if (o_hit !== 1'b0 || o_nwe !== 0) begin
      miscompares++;
      $display("[TB] FAIL evicted_lookup key=01: got hit=%b we=%0d want hit=0 we=0", o_hit, o_nwe);
    end
    model_req(1'b0, 9, mh, me, mw, ms);
    send_req(1'b0, 8'h09);
    wait_rsp();
    vectors++;
    if (o_hit !== 1'b1 || o_nwe !== 0) begin
      miscompares++;
      $display("[TB] FAIL newest_lookup key=09: got hit=%b we=%0d want hit=1 we=0", o_hit, o_nwe);
    end
  endtask

  task automatic test_backpressure();
    bit mh, me, mw;
    int ms;
    model_req(1'b0, 9, mh, me, mw, ms);
    send_req(1'b0, 8'h09);
    rsp_ready = 1'b0;
    wait_rsp();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      vectors++;
      if ({rsp_valid, rsp_hit, req_ready} !== {1'b1, mh, 1'b0}) begin
        miscompares++;
        $display("[TB] FAIL backpressure cycle %0d: got rv=%b hit=%b rr=%b want rv=1 hit=%b rr=0",
                 i, rsp_valid, rsp_hit, req_ready, mh);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (rsp_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL backpressure_release: got rv=%b want 0", rsp_valid);
    end
  endtask

  task automatic test_reset_in_write();
    bit mh, me, mw, seen;
    int ms;
    seen = 1'b0;
    send_req(1'b1, 8'h77);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (cam_we === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("[TB] FAIL write_not_reached: cam_we never rose for key 77");
    end
    rst_n   = 1'b0;
    cam_clr = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({cam_we, rsp_valid, req_ready, occupancy} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_in_write: got we=%b rv=%b rr=%b occ=%0d want all 0",
               cam_we, rsp_valid, req_ready, occupancy);
    end
    do_reset();
    model_req(1'b1, 8'h77, mh, me, mw, ms);
    send_req(1'b1, 8'h77);
    wait_rsp();
    vectors++;
    if (o_hit !== mh || o_waddr !== ms || o_occ !== m_occ || o_evict !== me) begin
      miscompares++;
      $display("[TB] FAIL after_reset_insert: got hit=%b wa=%0d occ=%0d ev=%b want hit=%b wa=%0d occ=%0d ev=%b",
               o_hit, o_waddr, o_occ, o_evict, mh, ms, m_occ, me);
    end
  endtask

  task automatic test_random();
    bit mh, me, mw, ins;
    int ms, elat, k, hold;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      ins = 1'($urandom_range(0, 1));
      k   = 32 + int'($urandom_range(0, 11));
      model_req(ins, k, mh, me, mw, ms);
      elat = mw ? 3 : 2;
      send_req(ins, 8'(k));
      hold      = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      rsp_ready = (hold == 0);
      wait_rsp();
      vectors++;
      if (o_hit !== mh || o_evict !== me) begin
        miscompares++;
        $display("[TB] FAIL rnd_status %0d op=%b key=%h: got hit=%b ev=%b want hit=%b ev=%b",
                 n, ins, k, o_hit, o_evict, mh, me);
      end
      vectors++;
      if (o_lat !== elat || o_busy_rdy !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL rnd_timing %0d: got lat=%0d busy_rr=%b want lat=%0d busy_rr=0",
                 n, o_lat, o_busy_rdy, elat);
      end
      vectors++;
      if (o_nwe !== int'(mw) || o_occ !== m_occ || (mw && (o_waddr !== ms || o_wkey !== k))) begin
        miscompares++;
        $display("[TB] FAIL rnd_write %0d: got we=%0d wa=%0d key=%0d occ=%0d want we=%0d wa=%0d key=%0d occ=%0d",
                 n, o_nwe, o_waddr, o_wkey, o_occ, mw, ms, k, m_occ);
      end
      if (hold != 0) begin
        repeat (hold) @(posedge clk);
        #1;
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_hit !== mh || rsp_evict !== me) begin
          miscompares++;
          $display("[TB] FAIL rnd_hold %0d: got rv=%b hit=%b ev=%b want rv=1 hit=%b ev=%b",
                   n, rsp_valid, rsp_hit, rsp_evict, mh, me);
        end
        rsp_ready = 1'b1;
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = 1'b0;
    req_key   = 8'h00;
    rsp_ready = 1'b1;
    cam_clr   = 1'b1;
    test_reset();
    test_insert_lookup();
    test_fill_evict();
    test_backpressure();
    test_reset_in_write();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
